// File: rtl/bus_ready_gen_if.sv
// bus_ready_gen_if
//   Groups the 8088 bus-cycle signals that the wait-state generator watches
//   together with the READY/status signals that it drives.
//   master : CPU/decode side. Drives the strobes and decode, and sees READY.
//   slave  : the wait-state generator itself.
//   Signals:
//     ale, iom, sel        cycle start, IO/memory select and OR of chip selects
//     rd_n, wr_n, inta_n   active-low bus strobes
//     ready                0 = insert a wait state
//     busy                 generator is not idle
//     wait_total           saturating count of wait cycles
//     err                  sticky protocol error
interface bus_ready_gen_if #(
  parameter int STAT_W = 16
);
  logic              ale;
  logic              iom;
  logic              sel;
  logic              rd_n;
  logic              wr_n;
  logic              inta_n;
  logic              ready;
  logic              busy;
  logic [STAT_W-1:0] wait_total;
  logic              err;

  modport master (
    output ale, iom, sel, rd_n, wr_n, inta_n,
    input  ready, busy, wait_total, err
  );

  modport slave (
    input  ale, iom, sel, rd_n, wr_n, inta_n,
    output ready, busy, wait_total, err
  );
endinterface

// File: rtl/bus_ready_gen.sv
// bus_ready_gen
//   Wait-state generator sitting between the address/chip-select decode and
//   the 8088 READY input. It pulls READY low for a number of clocks that
//   depends on the cycle type, so slow devices see stretched T3/Tw states.
//   It also counts the inserted wait cycles (saturating) and flags protocol
//   errors with a sticky bit.
//   Ports:
//     clk_i    system clock, all state changes on the rising edge
//     rst_n_i  asynchronous active-low reset
//     bus      slave modport of bus_ready_gen_if (strobes in, READY/status out)
//
//   state   | meaning
//   S_IDLE  | no bus cycle in progress, waiting for ALE
//   S_ARMED | address latched, count loaded, waiting for a strobe
//   S_WAIT  | READY held low, counting down the wait states
//   S_DONE  | waits finished, waiting for the strobe to be released
module bus_ready_gen #(
  parameter int MEM_WAITS  = 2,
  parameter int IO_WAITS   = 4,
  parameter int INTA_WAITS = 1,
  parameter int CNT_W      = 4,
  parameter int STAT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  bus_ready_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MEM_CNT  = CNT_W'(MEM_WAITS);
  localparam logic [CNT_W-1:0] IO_CNT   = CNT_W'(IO_WAITS);
  localparam logic [CNT_W-1:0] INTA_CNT = CNT_W'(INTA_WAITS);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              busy_q;
  logic [STAT_W-1:0] wait_total_q;
  logic              err_q;

  logic             strobe;
  logic             multi_strobe;
  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] eff_cnt;

  always_comb begin
    strobe       = ~bus.rd_n | ~bus.wr_n | ~bus.inta_n;
    multi_strobe = (~bus.rd_n & ~bus.wr_n) | (~bus.rd_n & ~bus.inta_n) |
                   (~bus.wr_n & ~bus.inta_n);
    load_cnt     = '0;
    if (bus.sel) begin
      load_cnt = bus.iom ? IO_CNT : MEM_CNT;
    end
    // INTA cycles use their own wait count regardless of decode
    eff_cnt = bus.inta_n ? cnt_q : INTA_CNT;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      wait_total_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (!ready_q && (wait_total_q != {STAT_W{1'b1}})) begin
        wait_total_q <= wait_total_q + STAT_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (bus.ale) begin
            cnt_q   <= load_cnt;
            state_q <= S_ARMED;
            busy_q  <= 1'b1;
          end
        end

        S_ARMED: begin
          if (bus.ale) begin
            cnt_q <= load_cnt;
          end else if (strobe) begin
            if (multi_strobe) begin
              err_q <= 1'b1;
            end
            cnt_q <= eff_cnt;
            if (eff_cnt == '0) begin
              state_q <= S_DONE;
            end else begin
              ready_q <= 1'b0;
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (!strobe) begin
            // strobe released before the waits ran out: abort the cycle
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            if (multi_strobe || bus.ale) begin
              err_q <= 1'b1;
            end
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              ready_q <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (bus.ale) begin
            // new cycle started while the old strobe was never seen released
            err_q   <= 1'b1;
            cnt_q   <= load_cnt;
            state_q <= S_ARMED;
          end else if (!strobe) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.wait_total = wait_total_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_bus_ready_gen.sv
module tb_bus_ready_gen;
  localparam int STAT_W = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  bus_ready_gen_if #(.STAT_W(STAT_W)) bus ();

  bus_ready_gen #(
    .MEM_WAITS (2),
    .IO_WAITS  (4),
    .INTA_WAITS(1),
    .CNT_W     (4),
    .STAT_W    (STAT_W)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ale    = 1'b0;
    bus.iom    = 1'b0;
    bus.sel    = 1'b0;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
    bus.inta_n = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Runs one full bus cycle: ALE, then the strobe held for 8 clocks, then
  // release. Returns how many sampled clocks showed READY low.
  // kind: 0 = RD, 1 = WR, 2 = INTA
  task automatic run_cycle(input logic iom, input logic sel, input int kind,
                           output int lows);
    bus.ale = 1'b1;
    bus.iom = iom;
    bus.sel = sel;
    tick();
    bus.ale = 1'b0;
    case (kind)
      0: bus.rd_n = 1'b0;
      1: bus.wr_n = 1'b0;
      default: bus.inta_n = 1'b0;
    endcase
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.ready === 1'b0) lows++;
    end
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
    bus.inta_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.ale = 1'b1; bus.iom = 1'b1; bus.sel = 1'b1;
    bus.rd_n = 1'b0; bus.wr_n = 1'b0; bus.inta_n = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    n_tests++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.wait_total !== 4'd0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: ready=%b busy=%b total=%0d err=%b, want 1 0 0 0",
               bus.ready, bus.busy, bus.wait_total, bus.err);
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.wait_total !== 4'd0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b busy=%b total=%0d err=%b, want 1 0 0 0",
               bus.ready, bus.busy, bus.wait_total, bus.err);
    end
  endtask

  task automatic test_mem_read();
    do_reset();
    bus.ale = 1'b1; bus.iom = 1'b0; bus.sel = 1'b1;
    tick();
    n_tests++;
    if (bus.busy !== 1'b1 || bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mem_armed: busy=%b ready=%b, want 1 1", bus.busy, bus.ready);
    end
    bus.ale = 1'b0; bus.rd_n = 1'b0;
    tick();
    n_tests++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_first_wait: ready=%b, want 0", bus.ready);
    end
    tick();
    n_tests++;
    if (bus.ready !== 1'b0 || bus.wait_total !== 4'd1) begin
      n_fail++;
      $display("FAIL mem_second_wait: ready=%b total=%0d, want 0 1", bus.ready, bus.wait_total);
    end
    tick();
    n_tests++;
    if (bus.ready !== 1'b1 || bus.wait_total !== 4'd2 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mem_done: ready=%b total=%0d busy=%b, want 1 2 1",
               bus.ready, bus.wait_total, bus.busy);
    end
    tick();
    n_tests++;
    if (bus.ready !== 1'b1 || bus.wait_total !== 4'd2) begin
      n_fail++;
      $display("FAIL mem_hold: ready=%b total=%0d, want 1 2", bus.ready, bus.wait_total);
    end
    bus.rd_n = 1'b1;
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_release: busy=%b err=%b, want 0 0", bus.busy, bus.err);
    end
  endtask

  task automatic test_io_and_unclaimed();
    int lows;
    do_reset();
    run_cycle(1'b1, 1'b1, 1, lows);
    n_tests++;
    if (lows != 4) begin
      n_fail++;
      $display("FAIL io_write_waits: got %0d low cycles, want 4", lows);
    end
    run_cycle(1'b0, 1'b0, 0, lows);
    n_tests++;
    if (lows != 0 || bus.wait_total !== 4'd4 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL unclaimed_read: lows=%0d total=%0d err=%b, want 0 4 0",
               lows, bus.wait_total, bus.err);
    end
  endtask

  task automatic test_inta();
    int lows;
    do_reset();
    run_cycle(1'b1, 1'b0, 2, lows);
    n_tests++;
    if (lows != 1 || bus.err !== 1'b0 || bus.wait_total !== 4'd1) begin
      n_fail++;
      $display("FAIL inta_waits: lows=%0d err=%b total=%0d, want 1 0 1",
               lows, bus.err, bus.wait_total);
    end
  endtask

  task automatic test_abort();
    int lows;
    do_reset();
    bus.ale = 1'b1; bus.iom = 1'b1; bus.sel = 1'b1;
    tick();
    bus.ale = 1'b0; bus.rd_n = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.ready !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre: ready=%b err=%b, want 0 0", bus.ready, bus.err);
    end
    bus.rd_n = 1'b1;
    tick();
    n_tests++;
    if (bus.ready !== 1'b1 || bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: ready=%b err=%b busy=%b, want 1 1 0", bus.ready, bus.err, bus.busy);
    end
    run_cycle(1'b0, 1'b1, 0, lows);
    n_tests++;
    if (lows != 2 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: lows=%0d err=%b, want 2 1", lows, bus.err);
    end
    do_reset();
    n_tests++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b, want 0", bus.err);
    end
  endtask

  task automatic test_protocol_errors();
    int lows;
    // RD and INTA together: INTA count wins, error flagged
    do_reset();
    bus.ale = 1'b1; bus.iom = 1'b1; bus.sel = 1'b1;
    tick();
    bus.ale = 1'b0; bus.rd_n = 1'b0; bus.inta_n = 1'b0;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.ready === 1'b0) lows++;
    end
    n_tests++;
    if (lows != 1 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_strobe: lows=%0d err=%b, want 1 1", lows, bus.err);
    end
    idle_inputs();
    tick();
    // ALE again in DONE with the strobe still held
    do_reset();
    bus.ale = 1'b1; bus.iom = 1'b0; bus.sel = 1'b1;
    tick();
    bus.ale = 1'b0; bus.rd_n = 1'b0;
    tick(); tick(); tick();
    bus.ale = 1'b1;
    tick();
    n_tests++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b1 || bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ale_in_done: err=%b busy=%b ready=%b, want 1 1 1", bus.err, bus.busy, bus.ready);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    int lows;
    // ALE during WAIT is ignored but flagged; the IO cycle still gets 4 waits
    do_reset();
    bus.ale = 1'b1; bus.iom = 1'b1; bus.sel = 1'b1;
    tick();
    bus.ale = 1'b0; bus.wr_n = 1'b0;
    lows = 0;
    tick();
    if (bus.ready === 1'b0) lows++;
    bus.ale = 1'b1; bus.iom = 1'b0;
    tick();
    if (bus.ready === 1'b0) lows++;
    bus.ale = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ready === 1'b0) lows++;
    end
    n_tests++;
    if (lows != 4 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL ale_in_wait: lows=%0d err=%b, want 4 1", lows, bus.err);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_saturation();
    int lows;
    do_reset();
    for (int c = 0; c < 3; c++) run_cycle(1'b1, 1'b1, 0, lows);
    n_tests++;
    if (bus.wait_total !== 4'd12) begin
      n_fail++;
      $display("FAIL total_12: got %0d, want 12", bus.wait_total);
    end
    for (int c = 0; c < 2; c++) run_cycle(1'b1, 1'b1, 0, lows);
    n_tests++;
    if (bus.wait_total !== 4'd15 || lows != 4) begin
      n_fail++;
      $display("FAIL total_saturate: total=%0d lows=%0d, want 15 4", bus.wait_total, lows);
    end
    // async reset in the middle of a wait
    bus.ale = 1'b1; bus.iom = 1'b1; bus.sel = 1'b1;
    tick();
    bus.ale = 1'b0; bus.rd_n = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait_pre: ready=%b, want 0", bus.ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.ready !== 1'b1 || bus.wait_total !== 4'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: ready=%b total=%0d busy=%b, want 1 0 0",
               bus.ready, bus.wait_total, bus.busy);
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_tests++;
    if (bus.ready !== 1'b1 || bus.wait_total !== 4'd0) begin
      n_fail++;
      $display("FAIL after_reset: ready=%b total=%0d, want 1 0", bus.ready, bus.wait_total);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_inputs();
    test_reset();
    test_mem_read();
    test_io_and_unclaimed();
    test_inta();
    test_abort();
    test_protocol_errors();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
